// File: rtl/execute_muldiv.sv
// Execute stage with operand forwarding, an ALU, and an iterative multiply/divide unit
// that stalls the pipe while it runs. The EX/MEM pipeline register is held inside this stage.
module execute_muldiv #(
  parameter int LEN          = 32,
  parameter int NB           = $clog2(LEN),
  parameter int LEN_EXEC_BUS = 14,
  parameter int LEN_MEM_BUS  = 9,
  parameter int LEN_WB_BUS   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LEN-1:0]          in_pc_branch,
  input  logic [LEN-1:0]          in_reg1,
  input  logic [LEN-1:0]          in_reg2,
  input  logic [LEN-1:0]          in_sign_extend,
  input  logic [NB-1:0]           in_rs,
  input  logic [NB-1:0]           in_rt,
  input  logic [NB-1:0]           in_rd,
  input  logic [NB-1:0]           in_shamt,
  input  logic [LEN_EXEC_BUS-1:0] execute_bus,
  input  logic [LEN_MEM_BUS-1:0]  memory_bus,
  input  logic [LEN_WB_BUS-1:0]   writeBack_bus,
  input  logic                    register_write_3_4,
  input  logic                    register_write_4_5,
  input  logic [NB-1:0]           rd_3_4,
  input  logic [NB-1:0]           rd_4_5,
  input  logic [LEN-1:0]          in_mem_forw,
  input  logic [LEN-1:0]          in_wb_forw,
  input  logic                    flush,
  output logic [LEN-1:0]          out_pc_branch,
  output logic [LEN-1:0]          out_alu,
  output logic [LEN-1:0]          out_reg2,
  output logic                    zero_flag,
  output logic [NB-1:0]           out_write_reg,
  output logic [LEN_MEM_BUS-1:0]  memory_bus_out,
  output logic [LEN_WB_BUS-1:0]   writeBack_bus_out,
  output logic                    stall
);

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [NB-1:0] LAST_STEP = NB'(LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [NB-1:0]   count;
  logic [LEN-1:0]  hi, lo;
  logic [LEN-1:0]  acc_hi, acc_lo, op_b;
  logic            is_div, neg_res, rem_neg, div_zero;

  logic [2:0]      md_op;
  logic            md_start, md_signed, a_neg, b_neg;
  logic [LEN-1:0]  fwd_a, fwd_b, op1, op2, alu_res, ex_result;
  logic [LEN-1:0]  a_mag, b_mag;
  logic [NB-1:0]   dest;
  logic [LEN:0]    mul_sum, div_shift, div_diff;
  logic [2*LEN-1:0] product, prod_fix;
  logic [LEN-1:0]  quot_fix, rem_fix;
  logic            unused_bus_bits;

  assign unused_bus_bits = &{1'b0, execute_bus[5:4]};

  assign md_op     = execute_bus[13:11];
  assign md_start  = (md_op != MD_NONE) && (md_op <= MD_DIVU);
  assign md_signed = (md_op == MD_MULT) || (md_op == MD_DIV);

  // MEM beats WB when both stages target the same register; r0 never forwards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    fwd_a = in_reg1;
    fwd_b = in_reg2;
    if (register_write_3_4 && rd_3_4 == in_rs && in_rs != '0)      fwd_a = in_mem_forw;
    else if (register_write_4_5 && rd_4_5 == in_rs && in_rs != '0) fwd_a = in_wb_forw;
    if (register_write_3_4 && rd_3_4 == in_rt && in_rt != '0)      fwd_b = in_mem_forw;
    else if (register_write_4_5 && rd_4_5 == in_rt && in_rt != '0) fwd_b = in_wb_forw;
  end

  always_comb begin
    op1 = fwd_a;
    op2 = fwd_b;
    if (execute_bus[10]) begin
      op1 = in_pc_branch;
      op2 = LEN'(1);
    end else begin
      if (execute_bus[7]) op1 = {{(LEN-NB){1'b0}}, in_shamt};
      if (execute_bus[6]) op2 = in_sign_extend;
    end
  end

  always_comb begin
    alu_res = '0;
    case (execute_bus[3:0])
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_AND:  alu_res = op1 & op2;
      ALU_OR:   alu_res = op1 | op2;
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_NOR:  alu_res = ~(op1 | op2);
      ALU_SLT:  alu_res = {{(LEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu_res = {{(LEN-1){1'b0}}, op1 < op2};
      ALU_SLL:  alu_res = op2 << op1[NB-1:0];
      ALU_SRL:  alu_res = op2 >> op1[NB-1:0];
      ALU_SRA:  alu_res = $signed(op2) >>> op1[NB-1:0];
      ALU_LUI:  alu_res = op2 << (LEN / 2);
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    ex_result = alu_res;
    if (md_op == MD_MFHI)      ex_result = hi;
    else if (md_op == MD_MFLO) ex_result = lo;
    dest = in_rt;
    if (execute_bus[9])      dest = '1;
    else if (execute_bus[8]) dest = in_rd;
  end

  // Operands are iterated as magnitudes; signs are reapplied when the result is written.
  assign a_neg = md_signed & fwd_a[LEN-1];
  assign b_neg = md_signed & fwd_b[LEN-1];
  assign a_mag = a_neg ? -fwd_a : fwd_a;
  assign b_mag = b_neg ? -fwd_b : fwd_b;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
  assign div_shift = {acc_hi, acc_lo[LEN-1]};
  assign div_diff  = div_shift - {1'b0, op_b};

  assign product  = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -product : product;
  assign quot_fix = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
  assign rem_fix  = rem_neg ? -acc_hi : acc_hi;

  assign stall = !reset && !flush && ((state == IDLE && md_start) || state == RUN);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      op_b     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (md_start) begin
          acc_hi   <= '0;
          acc_lo   <= a_mag;
          op_b     <= b_mag;
          is_div   <= (md_op == MD_DIV) || (md_op == MD_DIVU);
          neg_res  <= a_neg ^ b_neg;
          rem_neg  <= a_neg;
          div_zero <= (fwd_b == '0);
          count    <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (is_div) begin
            if (!div_diff[LEN]) begin
              acc_hi <= div_diff[LEN-1:0];
              acc_lo <= {acc_lo[LEN-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[LEN-1:0];
              acc_lo <= {acc_lo[LEN-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[LEN-1:1]};
          end
          count <= count + NB'(1);
          if (count == LAST_STEP) state <= DONE;
        end
        DONE: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM register: a bubble while stalled or flushed, the current instruction otherwise.
  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      out_pc_branch     <= '0;
      out_alu           <= '0;
      out_reg2          <= '0;
      zero_flag         <= 1'b0;
      out_write_reg     <= '0;
      memory_bus_out    <= '0;
      writeBack_bus_out <= '0;
    end else begin
      out_pc_branch     <= in_pc_branch + in_sign_extend;
      out_alu           <= ex_result;
      out_reg2          <= fwd_b;
      zero_flag         <= (ex_result == '0);
      out_write_reg     <= dest;
      memory_bus_out    <= memory_bus;
      writeBack_bus_out <= writeBack_bus;
    end
  end

endmodule
